// File: rtl/cam_capture_pkg.sv
// Shared camera/image parameters: default sensor and stored-image geometry,
// RGB444 bit positions and the capture FSM state encoding.
package cam_capture_pkg;

  localparam int c_in_cols_def     = 160;
  localparam int c_in_rows_def     = 120;
  localparam int c_img_cols_def    = 80;
  localparam int c_img_rows_def    = 60;
  localparam int c_nb_img_pxls_def = 13;
  localparam int c_nb_buf_def      = 12;

  // MSB of each 4-bit colour field inside a stored pixel word
  localparam int c_msb_red   = 11;
  localparam int c_msb_green = 7;
  localparam int c_msb_blue  = 3;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    CAPTURE    = 2'd2
  } cap_state_e;

endpackage

// File: rtl/rgb444_assembler.sv
// Pairs camera bytes into RGB444 pixels; a clear (line end or not capturing)
// drops any half-received pixel so the next byte is always a first byte.
module rgb444_assembler
  import cam_capture_pkg::*;
#(
  parameter int c_nb_buf = c_nb_buf_def
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                byte_valid,
  input  logic [7:0]          data,
  output logic                pxl_valid,
  output logic [c_nb_buf-1:0] pxl
);

  logic       phase;
  logic [3:0] red;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= 1'b0;
      red   <= 4'd0;
    end else if (clear) begin
      phase <= 1'b0;
    end else if (byte_valid) begin
      phase <= ~phase;
      if (!phase) red <= data[3:0];
    end
  end

  always_comb begin
    pxl                    = '0;
    pxl[c_msb_red   -: 4]  = red;
    pxl[c_msb_green -: 4]  = data[7:4];
    pxl[c_msb_blue  -: 4]  = data[3:0];
    pxl_valid              = byte_valid && phase && !clear;
  end

endmodule

// File: rtl/cam_capture.sv
// Camera frame capture: waits for a vsync high-to-low, assembles RGB444 pixels
// and stores every second pixel of every second line into the frame buffer.
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int c_in_cols     = c_in_cols_def,
  parameter int c_in_rows     = c_in_rows_def,
  parameter int c_img_cols    = c_img_cols_def,
  parameter int c_img_rows    = c_img_rows_def,
  parameter int c_nb_img_pxls = c_nb_img_pxls_def,
  parameter int c_nb_buf      = c_nb_buf_def
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap_en,
  input  logic                     cam_vsync,
  input  logic                     cam_href,
  input  logic [7:0]               cam_data,
  output logic                     orig_we,
  output logic [c_nb_img_pxls-1:0] orig_addr,
  output logic [c_nb_buf-1:0]      orig_pxl,
  output logic                     frame_done,
  output cap_state_e               dbg_state
);

  localparam int c_nb_col = $clog2(c_in_cols + 1);
  localparam int c_nb_row = $clog2(c_in_rows + 1);
  localparam logic [c_nb_col-1:0]      c_col_lim = c_nb_col'(c_in_cols);
  localparam logic [c_nb_row-1:0]      c_row_lim = c_nb_row'(c_in_rows);
  localparam logic [c_nb_img_pxls-1:0] c_last    = c_nb_img_pxls'(c_img_cols * c_img_rows - 1);

  cap_state_e state, state_nxt;

  logic                     capturing;
  logic                     done_evt;
  logic                     href_d;
  logic                     line_end;
  logic                     byte_valid;
  logic                     pxl_valid;
  logic                     wr_fire;
  logic                     full;
  logic [c_nb_col-1:0]      in_col;
  logic [c_nb_row-1:0]      in_row;
  logic [c_nb_img_pxls-1:0] wr_addr;
  logic [c_nb_buf-1:0]      asm_pxl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // The entry into WAIT_FRAME always happens with vsync high, so the first
  // low sample there is the high-to-low edge that starts a frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (cap_en && cam_vsync) state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (!cam_vsync)          state_nxt = CAPTURE;
      CAPTURE: begin
        if (full)           state_nxt = IDLE;
        else if (cam_vsync) state_nxt = WAIT_FRAME;
      end
      default:              state_nxt = IDLE;
    endcase
  end

  always_comb begin
    capturing = (state == CAPTURE);
    done_evt  = capturing && full;
    dbg_state = state;
  end

  always_comb begin
    line_end   = capturing && href_d && !cam_href;
    byte_valid = capturing && cam_href;
    wr_fire    = pxl_valid && !cam_vsync && !full &&
                 !in_col[0] && !in_row[0] &&
                 (in_col < c_col_lim) && (in_row < c_row_lim);
  end

  rgb444_assembler #(
    .c_nb_buf (c_nb_buf)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (line_end || !capturing),
    .byte_valid (byte_valid),
    .data       (cam_data),
    .pxl_valid  (pxl_valid),
    .pxl        (asm_pxl)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      href_d     <= 1'b0;
      orig_we    <= 1'b0;
      orig_addr  <= '0;
      orig_pxl   <= '0;
      frame_done <= 1'b0;
      in_col     <= '0;
      in_row     <= '0;
      wr_addr    <= '0;
      full       <= 1'b0;
    end else begin
      href_d     <= cam_href;
      orig_we    <= wr_fire;
      frame_done <= done_evt;
      if (wr_fire) begin
        orig_addr <= wr_addr;
        orig_pxl  <= asm_pxl;
      end
      if (!capturing) begin
        in_col  <= '0;
        in_row  <= '0;
        wr_addr <= '0;
        full    <= 1'b0;
      end else begin
        // Counters saturate at the sensor size so oversized input never wraps
        if (line_end) begin
          in_col <= '0;
          if (in_row != c_row_lim) in_row <= in_row + 1'b1;
        end else if (pxl_valid && (in_col != c_col_lim)) begin
          in_col <= in_col + 1'b1;
        end
        if (wr_fire) begin
          if (wr_addr == c_last) full    <= 1'b1;
          else                   wr_addr <= wr_addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// Randomized bench for cam_capture: a frame-level reference model predicts
// every buffer write and the frame_done count; a monitor checks the DUT.
module tb_cam_capture;
  import cam_capture_pkg::*;

  localparam int W        = 25;
  localparam int N_PIX    = 4800;
  localparam int IN_COLS  = 160;
  localparam int IN_ROWS  = 120;

  logic        clk = 1'b0;
  logic        rst;
  logic        cap_en;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        orig_we;
  logic [12:0] orig_addr;
  logic [11:0] orig_pxl;
  logic        frame_done;
  cap_state_e  dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_writes = 0;
  int exp_writes = 0;
  int done_seen = 0;
  int exp_done = 0;
  bit prev_we_last = 1'b0;

  // reference model state
  bit          m_cap = 1'b0;
  int          m_addr = 0;
  int          m_row = 0;
  logic [11:0] m_last_pxl = '0;

  cam_capture dut (
    .clk        (clk),
    .rst        (rst),
    .cap_en     (cap_en),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .orig_we    (orig_we),
    .orig_addr  (orig_addr),
    .orig_pxl   (orig_pxl),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_we"},    32'(orig_we),    32'd0);
    check({tag, "_addr"},  32'(orig_addr),  32'd0);
    check({tag, "_pxl"},   32'(orig_pxl),   32'd0);
    check({tag, "_done"},  32'(frame_done), 32'd0);
    check({tag, "_state"}, 32'(dbg_state),  32'(IDLE));
  endtask

  // ---------------- reference model ----------------
  task automatic model_pixel(input int col, input logic [11:0] pxl);
    if (m_cap && (col % 2 == 0) && (m_row % 2 == 0) && col < IN_COLS && m_row < IN_ROWS) begin
      exp_q.push_back({13'(m_addr), pxl});
      exp_writes++;
      m_last_pxl = pxl;
      m_addr++;
      if (m_addr == N_PIX) begin
        m_cap = 1'b0;
        exp_done++;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic vsync_pulse();
    @(negedge clk);
    cam_vsync = 1'b1;
    repeat (3) @(negedge clk);
    cam_vsync = 1'b0;
    // an active frame is aborted and re-armed; an idle one arms only if enabled
    if (m_cap || cap_en) begin
      m_cap  = 1'b1;
      m_addr = 0;
      m_row  = 0;
    end
    repeat ($urandom_range(2, 5)) @(negedge clk);
  endtask

  task automatic send_line(input int nbytes, input bit fixed_first);
    logic [7:0] b, first;
    first = '0;
    for (int i = 0; i < nbytes; i++) begin
      b = 8'($urandom_range(0, 255));
      if (fixed_first && i == 0) b = 8'h0A;
      if (fixed_first && i == 1) b = 8'h5C;
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = b;
      if (i % 2 == 0) first = b;
      else            model_pixel(i / 2, {first[3:0], b});
    end
    @(negedge clk);
    cam_href = 1'b0;
    cam_data = 8'($urandom_range(0, 255));
    repeat ($urandom_range(2, 5)) @(negedge clk);
    if (m_cap) m_row++;
  endtask

  // odd-row line with an asynchronous reset pulse in the middle
  task automatic send_line_rst(input int nbytes, input int rst_at);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = 8'($urandom_range(0, 255));
      if (i == rst_at) begin
        check("queue_drained_before_reset", 32'(exp_q.size()), 32'd0);
        #1 rst = 1'b0;
        m_cap  = 1'b0;
        m_addr = 0;
        m_row  = 0;
        #1 check_outputs_zero("async_reset");
      end
      if (i == rst_at + 3) rst = 1'b1;
    end
    @(negedge clk);
    cam_href = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    if (orig_we) begin
      n_writes++;
      got = {orig_addr, orig_pxl};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d pxl=0x%03h, required no write", orig_addr, orig_pxl);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL write: got addr=%0d pxl=0x%03h, required addr=%0d pxl=0x%03h",
                   orig_addr, orig_pxl, exp[24:12], exp[11:0]);
        end
      end
    end
    if (frame_done) begin
      done_seen++;
      checks++;
      if (!prev_we_last) begin
        errors++;
        $display("FAIL frame_done_timing: got pulse without write to 4799 one cycle earlier, required pulse right after it");
      end
    end
    prev_we_last = orig_we && (orig_addr == 13'd4799);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b0;
    cap_en    = 1'b0;
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cam_data  = 8'd0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // capture disabled: vsync pulses must not start a frame
    vsync_pulse();
    for (int l = 0; l < 3; l++) send_line(320, 1'b0);
    check("disabled_state", 32'(dbg_state), 32'(IDLE));

    // frame aborted after 30 lines; first line has an odd byte count
    cap_en = 1'b1;
    vsync_pulse();
    send_line(321, 1'b0);
    for (int l = 1; l < 30; l++) send_line((l % 3 == 0) ? $urandom_range(300, 330) : 320, 1'b0);
    check("abort_no_done", 32'(done_seen), 32'd0);

    // full frame; cap_en dropped partway through must not stop it
    vsync_pulse();
    send_line(320, 1'b1);
    for (int l = 1; l < IN_ROWS; l++) begin
      if (l == 10) cap_en = 1'b0;
      send_line(320, 1'b0);
    end
    check("full_frame_done", 32'(done_seen), 32'd1);
    check("hold_addr", 32'(orig_addr), 32'd4799);
    check("hold_pxl", 32'(orig_pxl), 32'(m_last_pxl));
    check("hold_we", 32'(orig_we), 32'd0);
    check("after_frame_state", 32'(dbg_state), 32'(IDLE));

    // idle with capture disabled: nothing written
    for (int l = 0; l < 2; l++) send_line(320, 1'b0);
    vsync_pulse();
    for (int l = 0; l < 2; l++) send_line(320, 1'b0);

    // reset in the middle of a line, then restart on a fresh vsync edge
    cap_en = 1'b1;
    vsync_pulse();
    for (int l = 0; l < 3; l++) send_line(320, 1'b0);
    send_line_rst(200, 101);
    send_line(320, 1'b0);
    check("post_reset_idle", 32'(dbg_state), 32'(IDLE));
    vsync_pulse();
    for (int l = 0; l < 3; l++) send_line(320, 1'b0);

    repeat (10) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("write_count", 32'(n_writes), 32'(exp_writes));
    check("done_count", 32'(done_seen), 32'(exp_done));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
